// File: rtl/mem_stage.sv
// Memory-stage controller: issues one data-memory access at a time, stalls the
// pipeline while it is outstanding and flags illegal accesses and timeouts.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResIn,
  input  logic [15:0] writeDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic        RegWriteIn,
  input  logic [2:0]  writeRegIn,
  input  logic        writeRegValidIn,
  output logic        memReq,
  output logic        memWe,
  output logic [15:0] memAddr,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  input  logic        memDone,
  output logic        stall,
  output logic [15:0] memDataOut,
  output logic [15:0] aluResOut,
  output logic [2:0]  writeRegOut,
  output logic        MemToRegOut,
  output logic        RegWriteOut,
  output logic        MemReadOut,
  output logic        writeRegValidOut,
  output logic        errOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_count;
  logic [15:0] data_reg;
  logic        err_reg;
  logic        access;
  logic        illegal;
  logic        timed_out;
  logic        drop_illegal;

  assign access       = MemReadIn | MemWriteIn;
  assign illegal      = (MemReadIn & MemWriteIn) | (access & aluResIn[0]);
  assign drop_illegal = (state == IDLE) && access && illegal;
  assign timed_out    = (state == WAIT) && !memDone && (wait_count == LAST_WAIT);

  assign memAddr  = aluResIn;
  assign memWdata = writeDataIn;
  assign errOut   = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_count <= 8'd0;
      data_reg   <= 16'h0000;
      err_reg    <= 1'b0;
    end else begin
      state <= state_next;
      // The counter sits at zero outside WAIT so every access starts a fresh count.
      if (state == WAIT) begin
        wait_count <= wait_count + 8'd1;
        if (memDone) begin
          data_reg <= memRdata;
        end
      end else begin
        wait_count <= 8'd0;
      end
      if (drop_illegal || timed_out) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state;
    memReq           = 1'b0;
    memWe            = 1'b0;
    stall            = 1'b0;
    memDataOut       = 16'h0000;
    aluResOut        = 16'h0000;
    writeRegOut      = 3'd0;
    MemToRegOut      = 1'b0;
    RegWriteOut      = 1'b0;
    MemReadOut       = 1'b0;
    writeRegValidOut = 1'b0;

    case (state)
      IDLE: begin
        if (!access) begin
          aluResOut        = aluResIn;
          writeRegOut      = writeRegIn;
          MemToRegOut      = MemToRegIn;
          RegWriteOut      = RegWriteIn;
          MemReadOut       = MemReadIn;
          writeRegValidOut = writeRegValidIn;
        end else if (!illegal) begin
          memReq     = 1'b1;
          memWe      = MemWriteIn;
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A timeout drops to IDLE while still stalled, so the held instruction re-issues.
        stall = 1'b1;
        if (memDone) begin
          state_next = RESP;
        end else if (wait_count == LAST_WAIT) begin
          state_next = IDLE;
        end
      end
      RESP: begin
        aluResOut        = aluResIn;
        writeRegOut      = writeRegIn;
        MemToRegOut      = MemToRegIn;
        RegWriteOut      = RegWriteIn;
        MemReadOut       = MemReadIn;
        writeRegValidOut = writeRegValidIn;
        memDataOut       = MemReadIn ? data_reg : 16'h0000;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus random instruction streams checked
// against a per-instruction trace model of the stage.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [15:0] aluResIn;
  logic [15:0] writeDataIn;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic        MemToRegIn;
  logic        RegWriteIn;
  logic [2:0]  writeRegIn;
  logic        writeRegValidIn;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic [15:0] memRdata;
  logic        memDone;
  logic        stall;
  logic [15:0] memDataOut;
  logic [15:0] aluResOut;
  logic [2:0]  writeRegOut;
  logic        MemToRegOut;
  logic        RegWriteOut;
  logic        MemReadOut;
  logic        writeRegValidOut;
  logic        errOut;

  int assertCount;
  int failCount;
  bit errExp;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .aluResIn(aluResIn), .writeDataIn(writeDataIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .MemToRegIn(MemToRegIn), .RegWriteIn(RegWriteIn),
    .writeRegIn(writeRegIn), .writeRegValidIn(writeRegValidIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memDone(memDone), .stall(stall),
    .memDataOut(memDataOut), .aluResOut(aluResOut), .writeRegOut(writeRegOut),
    .MemToRegOut(MemToRegOut), .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
    .writeRegValidOut(writeRegValidOut), .errOut(errOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic mtr, input logic rw,
                               input logic [2:0] wreg, input logic wv,
                               input logic [15:0] addr, input logic [15:0] wdata);
    MemReadIn       = rd;
    MemWriteIn      = wr;
    MemToRegIn      = mtr;
    RegWriteIn      = rw;
    writeRegIn      = wreg;
    writeRegValidIn = wv;
    aluResIn        = addr;
    writeDataIn     = wdata;
  endtask

  // Bundle layout: {aluRes, memData, writeReg, MemToReg, RegWrite, MemRead, writeRegValid}
  task automatic expectCycle(input string tag, input bit eStall, input bit eReq, input bit eWe,
                             input logic [15:0] eAddr, input logic [15:0] eWdata,
                             input logic [38:0] eBundle);
    @(negedge clk);
    checkOutput({tag, ".stall"}, 64'(stall), 64'(eStall));
    checkOutput({tag, ".memReq"}, 64'(memReq), 64'(eReq));
    if (eReq) begin
      checkOutput({tag, ".memWe"}, 64'(memWe), 64'(eWe));
      checkOutput({tag, ".memAddr"}, 64'(memAddr), 64'(eAddr));
      checkOutput({tag, ".memWdata"}, 64'(memWdata), 64'(eWdata));
    end
    checkOutput({tag, ".pipe"},
                64'({aluResOut, memDataOut, writeRegOut, MemToRegOut, RegWriteOut, MemReadOut, writeRegValidOut}),
                64'(eBundle));
    checkOutput({tag, ".errOut"}, 64'(errOut), 64'(errExp));
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour for one instruction: lat is the number of cycles after the
  // request at which the memory answers (lat > TO means it never answers in time).
  task automatic runInstr(input string tag, input logic rd, input logic wr, input logic mtr,
                          input logic rw, input logic [2:0] wreg, input logic wv,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input int lat, input bit earlyDone, input logic [15:0] rdval);
    bit          isAccess;
    bit          isIllegal;
    bit          finished;
    bit          answered;
    int          curLat;
    bit          curEarly;
    logic [38:0] passBundle;
    logic [38:0] respBundle;
    applyStimulus(rd, wr, mtr, rw, wreg, wv, addr, wdata);
    isAccess   = rd | wr;
    isIllegal  = (rd & wr) | (isAccess & addr[0]);
    passBundle = {addr, 16'h0000, wreg, mtr, rw, rd, wv};
    respBundle = {addr, (rd ? rdval : 16'h0000), wreg, mtr, rw, rd, wv};
    if (!isAccess) begin
      memDone  = 1'($urandom_range(0, 1));
      memRdata = 16'($urandom);
      expectCycle({tag, ".pass"}, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, passBundle);
      memDone = 1'b0;
    end else if (isIllegal) begin
      memDone  = 1'($urandom_range(0, 1));
      memRdata = 16'($urandom);
      expectCycle({tag, ".illegal"}, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 39'h0);
      memDone = 1'b0;
      errExp  = 1'b1;
    end else begin
      finished = 1'b0;
      curLat   = lat;
      curEarly = earlyDone;
      while (!finished) begin
        memDone  = curEarly;
        memRdata = 16'($urandom);
        expectCycle({tag, ".req"}, 1'b1, 1'b1, wr, addr, wdata, 39'h0);
        answered = 1'b0;
        for (int k = 1; k <= TO && !answered; k++) begin
          memDone  = (k == curLat);
          memRdata = (k == curLat) ? rdval : 16'($urandom);
          expectCycle({tag, ".wait"}, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 39'h0);
          answered = (k == curLat);
        end
        if (answered) begin
          memDone  = 1'($urandom_range(0, 1));
          memRdata = 16'($urandom);
          expectCycle({tag, ".resp"}, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, respBundle);
          memDone  = 1'b0;
          finished = 1'b1;
        end else begin
          errExp   = 1'b1;
          curLat   = $urandom_range(1, TO);
          curEarly = 1'b1;
        end
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    errExp      = 1'b0;
    rst         = 1'b1;
    memDone     = 1'b0;
    memRdata    = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expectCycle("reset", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 39'h0);

    runInstr("passThru", 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 16'h1234, 16'h0000, 1, 1'b0, 16'h0);
    runInstr("loadL3", 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 16'h0040, 16'h0000, 3, 1'b0, 16'hBEEF);
    runInstr("storeL1", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0010, 16'h00AA, 1, 1'b0, 16'h1357);
    runInstr("loadLTO", 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 16'h0022, 16'h0000, TO, 1'b0, 16'h7E57);
    runInstr("misalign", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 16'h0041, 16'h0000, 1, 1'b0, 16'h0);
    runInstr("rdAndWr", 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 16'h0044, 16'h0099, 1, 1'b0, 16'h0);

    // Clear the sticky error, then exercise the timeout and its re-issue.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    errExp = 1'b0;
    runInstr("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 16'h0100, 16'h0000, 99, 1'b0, 16'hCAFE);

    // Reset two cycles after the request, then a stray memDone must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 16'h0080, 16'h0000);
    memDone = 1'b0;
    expectCycle("rstReq", 1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 39'h0);
    expectCycle("rstWait1", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 39'h0);
    rst = 1'b1;
    expectCycle("rstWait2", 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 39'h0);
    rst    = 1'b0;
    errExp = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 16'h5555, 16'h0000);
    memDone  = 1'b1;
    memRdata = 16'hFFFF;
    expectCycle("rstAfter", 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, {16'h5555, 16'h0000, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1});
    memDone = 1'b0;
    runInstr("postRst", 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 16'h0202, 16'h0000, 2, 1'b0, 16'hA5A5);

    for (int n = 0; n < 300; n++) begin
      int          cls;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      cls  = $urandom_range(0, 9);
      addr = 16'($urandom);
      rd   = 1'b0;
      wr   = 1'b0;
      if (cls >= 3 && cls < 5) begin
        rd      = 1'b1;
        addr[0] = 1'b0;
      end else if (cls >= 5 && cls < 7) begin
        wr      = 1'b1;
        addr[0] = 1'b0;
      end else if (cls == 7) begin
        rd      = 1'($urandom_range(0, 1));
        wr      = ~rd;
        addr[0] = 1'b1;
      end else if (cls == 8) begin
        rd = 1'b1;
        wr = 1'b1;
      end else if (cls == 9) begin
        rd      = 1'b1;
        addr[0] = 1'b0;
      end
      runInstr("rand", rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), addr, 16'($urandom),
               $urandom_range(1, TO + 1), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
